// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared state encoding and constants for the ID-stage hazard unit
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LOADUSE = 2'd1,
    S_JRWAIT  = 2'd2
  } state_t;

  localparam int REG_ZERO    = 0;
  localparam int BUB_CNT_W   = 2;

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-side bundle between the datapath and the hazard unit
interface hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  id_j;
  logic                  id_jr;
  logic                  ex_memRead;
  logic                  ex_regWrite;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  mem_memRead;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic                  branch_taken;
  logic                  clr_counts;
  logic                  stall;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  flush_ifid;
  logic                  flush_idex;
  logic                  flush_exmem;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_j, id_jr, ex_memRead, ex_regWrite, ex_dst,
           mem_memRead, mem_dst, branch_taken, clr_counts,
    input  stall, pc_write, ifid_write, flush_ifid, flush_idex, flush_exmem,
           stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_j, id_jr, ex_memRead, ex_regWrite, ex_dst,
           mem_memRead, mem_dst, branch_taken, clr_counts,
    output stall, pc_write, ifid_write, flush_ifid, flush_idex, flush_exmem,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// rtl/hazard_unit_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use / jr hazard stall and control-flow flush controller
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W      = 5,
  parameter int LOADUSE_BUBBLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  hazard_unit_if.slave hu
);

  localparam logic [BUB_CNT_W-1:0] LU_LOAD = BUB_CNT_W'(LOADUSE_BUBBLES - 1);
  localparam logic [REG_ADDR_W-1:0] RZ     = REG_ADDR_W'(REG_ZERO);

  state_t               state, next_state;
  logic [BUB_CNT_W-1:0] bub_cnt, next_cnt;
  logic                 lu, jh, hz_bubble, redirect;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic dep(input logic [REG_ADDR_W-1:0] dst, input logic [REG_ADDR_W-1:0] src);
    return (dst != RZ) && (dst == src);
  endfunction

  assign lu = hu.ex_memRead & (dep(hu.ex_dst, hu.id_rs) | (hu.id_uses_rt & dep(hu.ex_dst, hu.id_rt)));
  assign jh = hu.id_jr & ((hu.ex_regWrite & dep(hu.ex_dst, hu.id_rs)) |
                          (hu.mem_memRead & dep(hu.mem_dst, hu.id_rs)));

  always_comb begin
    hu.stall       = 1'b1;
    hu.pc_write    = 1'b1;
    hu.ifid_write  = 1'b1;
    hu.flush_ifid  = 1'b0;
    hu.flush_idex  = 1'b0;
    hu.flush_exmem = 1'b0;
    next_state     = state;
    next_cnt       = bub_cnt;
    hz_bubble      = 1'b0;
    redirect       = 1'b0;
    if (hu.branch_taken) begin
      hu.flush_ifid  = 1'b1;
      hu.flush_idex  = 1'b1;
      hu.flush_exmem = 1'b1;
      hu.stall       = 1'b0;
      next_state     = S_RUN;
      next_cnt       = '0;
      redirect       = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (lu) begin
            hu.stall      = 1'b0;
            hu.pc_write   = 1'b0;
            hu.ifid_write = 1'b0;
            hz_bubble     = 1'b1;
            next_cnt      = LU_LOAD;
            next_state    = (LOADUSE_BUBBLES == 1) ? S_RUN : S_LOADUSE;
          end else if (jh) begin
            hu.stall      = 1'b0;
            hu.pc_write   = 1'b0;
            hu.ifid_write = 1'b0;
            hz_bubble     = 1'b1;
            next_state    = S_JRWAIT;
          end else if (hu.id_j || hu.id_jr) begin
            hu.flush_ifid = 1'b1;
            redirect      = 1'b1;
          end
        end
        S_LOADUSE: begin
          hu.stall      = 1'b0;
          hu.pc_write   = 1'b0;
          hu.ifid_write = 1'b0;
          hz_bubble     = 1'b1;
          next_cnt      = (bub_cnt != '0) ? bub_cnt - 1'b1 : '0;
          if (bub_cnt <= 1) next_state = S_RUN;
        end
        S_JRWAIT: begin
          if (jh) begin
            hu.stall      = 1'b0;
            hu.pc_write   = 1'b0;
            hu.ifid_write = 1'b0;
            hz_bubble     = 1'b1;
          end else begin
            hu.flush_ifid = 1'b1;
            redirect      = 1'b1;
            next_state    = S_RUN;
          end
        end
        default: next_state = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      bub_cnt <= '0;
    end else begin
      state   <= next_state;
      bub_cnt <= next_cnt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hz_bubble),
    .clr   (hu.clr_counts),
    .q     (hu.stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .clr   (hu.clr_counts),
    .q     (hu.flush_events)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed bench for hazard_unit with 1-bubble and 3-bubble instances
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) h1 ();
  hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) h3 ();

  assign h3.id_rs        = h1.id_rs;
  assign h3.id_rt        = h1.id_rt;
  assign h3.id_uses_rt   = h1.id_uses_rt;
  assign h3.id_j         = h1.id_j;
  assign h3.id_jr        = h1.id_jr;
  assign h3.ex_memRead   = h1.ex_memRead;
  assign h3.ex_regWrite  = h1.ex_regWrite;
  assign h3.ex_dst       = h1.ex_dst;
  assign h3.mem_memRead  = h1.mem_memRead;
  assign h3.mem_dst      = h1.mem_dst;
  assign h3.branch_taken = h1.branch_taken;
  assign h3.clr_counts   = h1.clr_counts;

  hazard_unit #(.REG_ADDR_W(5), .LOADUSE_BUBBLES(1), .CNT_W(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .hu    (h1.slave)
  );

  hazard_unit #(.REG_ADDR_W(5), .LOADUSE_BUBBLES(3), .CNT_W(16)) dut3 (
    .clk   (clk),
    .reset (reset),
    .hu    (h3.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    h1.id_rs        = '0;
    h1.id_rt        = '0;
    h1.id_uses_rt   = 1'b0;
    h1.id_j         = 1'b0;
    h1.id_jr        = 1'b0;
    h1.ex_memRead   = 1'b0;
    h1.ex_regWrite  = 1'b0;
    h1.ex_dst       = '0;
    h1.mem_memRead  = 1'b0;
    h1.mem_dst      = '0;
    h1.branch_taken = 1'b0;
    h1.clr_counts   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    h1.clr_counts = 1'b1;
    tick();
    h1.clr_counts = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    #1;
    check("rst_stall",      32'(h1.stall),        32'd1);
    check("rst_pc_write",   32'(h1.pc_write),     32'd1);
    check("rst_ifid_write", 32'(h1.ifid_write),   32'd1);
    check("rst_flushes",    32'({h1.flush_ifid, h1.flush_idex, h1.flush_exmem}), 32'd0);
    check("rst_stall_cnt",  32'(h1.stall_cycles), 32'd0);
    check("rst_flush_cnt",  32'(h1.flush_events), 32'd0);
    reset = 1'b0;
    tick();

    // load-use on rs: one bubble in dut1, three in dut3
    h1.ex_memRead = 1'b1; h1.ex_dst = 5'd2; h1.id_rs = 5'd2; h1.id_rt = 5'd7; h1.id_uses_rt = 1'b1;
    #1;
    check("lu1_stall",    32'(h1.stall),      32'd0);
    check("lu1_pc_write", 32'(h1.pc_write),   32'd0);
    check("lu1_ifid",     32'(h1.ifid_write), 32'd0);
    check("lu3_stall_c0", 32'(h3.stall),      32'd0);
    tick();
    idle();
    #1;
    check("lu1_release",   32'(h1.stall),        32'd1);
    check("lu1_pc_resume", 32'(h1.pc_write),     32'd1);
    check("lu1_stall_cnt", 32'(h1.stall_cycles), 32'd1);
    check("lu3_stall_c1",  32'(h3.stall),        32'd0);
    tick();
    #1;
    check("lu3_stall_c2",  32'(h3.stall),        32'd0);
    tick();
    #1;
    check("lu3_release",   32'(h3.stall),        32'd1);
    check("lu3_stall_cnt", 32'(h3.stall_cycles), 32'd3);

    // rt match only counts when the instruction reads rt
    h1.ex_memRead = 1'b1; h1.ex_dst = 5'd7; h1.id_rs = 5'd3; h1.id_rt = 5'd7; h1.id_uses_rt = 1'b1;
    #1;
    check("lu_rt_stall", 32'(h1.stall), 32'd0);
    h1.id_uses_rt = 1'b0;
    #1;
    check("lu_rt_unused", 32'(h1.stall), 32'd1);

    // register 0 never hazards
    h1.ex_dst = 5'd0; h1.id_rs = 5'd0; h1.id_rt = 5'd0; h1.id_uses_rt = 1'b1;
    #1;
    check("r0_stall1", 32'(h1.stall), 32'd1);
    check("r0_stall3", 32'(h3.stall), 32'd1);
    tick();
    idle();
    clear_counts();
    #1;
    check("clr_stall_cnt", 32'(h1.stall_cycles), 32'd0);

    // jr waits on EX write then MEM load, then redirects once
    h1.id_jr = 1'b1; h1.id_rs = 5'd5; h1.ex_regWrite = 1'b1; h1.ex_dst = 5'd5;
    #1;
    check("jr_ex_stall", 32'(h1.stall),    32'd0);
    check("jr_ex_pc",    32'(h1.pc_write), 32'd0);
    tick();
    h1.ex_regWrite = 1'b0; h1.ex_dst = 5'd0; h1.mem_memRead = 1'b1; h1.mem_dst = 5'd5;
    #1;
    check("jr_mem_stall", 32'(h1.stall),      32'd0);
    check("jr_mem_flush", 32'(h1.flush_ifid), 32'd0);
    tick();
    h1.mem_memRead = 1'b0; h1.mem_dst = 5'd0;
    #1;
    check("jr_go_flush", 32'(h1.flush_ifid), 32'd1);
    check("jr_go_stall", 32'(h1.stall),      32'd1);
    check("jr_go_pc",    32'(h1.pc_write),   32'd1);
    tick();
    idle();
    #1;
    check("jr_flush_once", 32'(h1.flush_ifid),   32'd0);
    check("jr_flush_cnt",  32'(h1.flush_events), 32'd1);
    check("jr_stall_cnt",  32'(h1.stall_cycles), 32'd2);

    // plain j flushes IF/ID without stalling
    h1.id_j = 1'b1;
    #1;
    check("j_flush_ifid", 32'(h1.flush_ifid), 32'd1);
    check("j_flush_idex", 32'(h1.flush_idex), 32'd0);
    check("j_stall",      32'(h1.stall),      32'd1);
    tick();
    idle();
    #1;
    check("j_flush_cnt", 32'(h1.flush_events), 32'd2);
    clear_counts();

    // branch_taken aborts S_LOADUSE in dut3
    h1.ex_memRead = 1'b1; h1.ex_dst = 5'd4; h1.id_rs = 5'd4;
    tick();
    idle();
    h1.branch_taken = 1'b1;
    #1;
    check("br_flushes3", 32'({h3.flush_ifid, h3.flush_idex, h3.flush_exmem}), 32'd7);
    check("br_pc3",      32'(h3.pc_write), 32'd1);
    check("br_stall3",   32'(h3.stall),    32'd0);
    tick();
    idle();
    #1;
    check("br_stall_cnt3", 32'(h3.stall_cycles), 32'd1);
    check("br_flush_cnt3", 32'(h3.flush_events), 32'd1);
    check("br_resume3",    32'(h3.stall),        32'd1);
    clear_counts();

    // saturation, then clear wins over increment
    h1.ex_memRead = 1'b1; h1.ex_dst = 5'd9; h1.id_rs = 5'd9;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_stall_cnt1", 32'(h1.stall_cycles), 32'h0000FFFF);
    check("sat_stall_cnt3", 32'(h3.stall_cycles), 32'h0000FFFF);
    tick();
    check("sat_hold1", 32'(h1.stall_cycles), 32'h0000FFFF);
    h1.clr_counts = 1'b1;
    tick();
    h1.clr_counts = 1'b0;
    #1;
    check("sat_clr1", 32'(h1.stall_cycles), 32'd0);
    idle();
    tick();

    // reset while in S_JRWAIT
    h1.id_jr = 1'b1; h1.id_rs = 5'd6; h1.ex_regWrite = 1'b1; h1.ex_dst = 5'd6;
    tick();
    #1;
    check("jrw_hold", 32'(h1.stall), 32'd0);
    idle();
    reset = 1'b1;
    tick();
    #1;
    check("jrw_rst_stall", 32'(h1.stall),      32'd1);
    check("jrw_rst_flush", 32'(h1.flush_ifid), 32'd0);
    reset = 1'b0;
    tick();
    #1;
    check("jrw_post_flush", 32'(h1.flush_ifid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
